// File: rtl/crc7_cmd_sequencer.sv
// crc7_cmd_sequencer: builds a 48-bit SD command frame by streaming the body through a CRC7 peripheral.
module crc7_cmd_sequencer #(
    parameter int   TIMEOUT   = 255,
    parameter logic CS_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [47:0] frame,
    output logic        p_cs,
    output logic [3:0]  p_addr,
    output logic        p_rd,
    output logic        p_wr,
    output logic [15:0] p_wdata,
    input  logic [15:0] p_rdata
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [3:0] {IDLE, WR_DATA, START_HI, START_LO, POLL, READ, CAPTURE, DONE, ERR} state_t;
    state_t      state_q, state_d;
    logic [39:0] body_q, body_d;
    logic [1:0]  word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [6:0]  crc_q, crc_d;
    logic [47:0] frame_q, frame_d;
    logic [15:0] word_data;
    logic        unused_rdata;
    assign unused_rdata = ^p_rdata[15:7];
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            body_q  <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            crc_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            body_q  <= body_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            crc_q   <= crc_d;
            frame_q <= frame_d;
        end
    end
    assign word_data = (word_q == 2'd0) ? body_q[39:24] :
                       (word_q == 2'd1) ? body_q[23:8] : {body_q[7:0], 8'h00};
    always_comb begin
        state_d = state_q;
        body_d  = body_q;
        word_d  = word_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        crc_d   = crc_q;
        frame_d = frame_q;
        p_cs    = ~CS_ACTIVE;
        p_addr  = 4'h0;
        p_rd    = 1'b0;
        p_wr    = 1'b0;
        p_wdata = 16'h0000;
        case (state_q)
            IDLE: begin
                if (start) begin
                    body_d  = {2'b01, cmd_index, cmd_arg};
                    err_d   = 1'b0;
                    word_d  = 2'd0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                p_cs    = CS_ACTIVE;
                p_wr    = 1'b1;
                p_wdata = word_data;
                state_d = START_HI;
            end
            START_HI, START_LO: begin
                p_cs    = CS_ACTIVE;
                p_wr    = 1'b1;
                p_addr  = 4'h2;
                // clear CRC on the first word, byte mode on the padded last word
                p_wdata = {13'b0, word_q == 2'd2, word_q == 2'd0, state_q == START_HI};
                tmo_d   = '0;
                state_d = (state_q == START_HI) ? START_LO : POLL;
            end
            POLL: begin
                p_cs   = CS_ACTIVE;
                p_rd   = 1'b1;
                p_addr = 4'h4;
                if (p_rdata[0]) begin
                    word_d  = (word_q < 2'd2) ? word_q + 2'd1 : word_q;
                    state_d = (word_q < 2'd2) ? WR_DATA : READ;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            READ, CAPTURE: begin
                p_cs   = CS_ACTIVE;
                p_rd   = 1'b1;
                p_addr = 4'h6;
                if (state_q == CAPTURE) begin
                    crc_d   = p_rdata[6:0];
                    frame_d = {body_q, p_rdata[6:0], 1'b1};
                end
                state_d = (state_q == READ) ? CAPTURE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy  = !(state_q inside {IDLE, DONE, ERR});
    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign frame = frame_q;
endmodule

// File: tb/tb_crc7_cmd_sequencer.sv
// tb_crc7_cmd_sequencer: self-checking bench with a CRC7 peripheral model and a polynomial-division reference.
module tb_crc7_cmd_sequencer;
    localparam int TMO = 255;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        busy, done, err, p_cs, p_rd, p_wr;
    logic [47:0] frame;
    logic [3:0]  p_addr;
    logic [15:0] p_wdata, p_rdata;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;

    crc7_cmd_sequencer #(.TIMEOUT(TMO), .CS_ACTIVE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .busy(busy), .done(done), .err(err), .frame(frame), .p_cs(p_cs), .p_addr(p_addr),
        .p_rd(p_rd), .p_wr(p_wr), .p_wdata(p_wdata), .p_rdata(p_rdata));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC peripheral model: register file plus a done countdown
    logic [15:0] pd_q = '0;
    logic [6:0]  pc_q = '0;
    int          pcnt = 0, p_extra = 0;
    bit          p_never = 0;
    function automatic logic [6:0] pcrc(input logic [6:0] c0, input logic [15:0] d, input bit bytem);
        logic [6:0] c;
        logic fb;
        c = c0;
        for (int i = 0; i < (bytem ? 8 : 16); i++) begin
            fb = c[6] ^ d[15-i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction
    always @(posedge clk) begin
        if (pcnt > 0) pcnt <= pcnt - 1;
        if (p_wr && p_addr == 4'h0) pd_q <= p_wdata;
        if (p_wr && p_addr == 4'h2 && p_wdata[0]) begin
            pc_q <= pcrc(p_wdata[1] ? 7'd0 : pc_q, pd_q, p_wdata[2]);
            pcnt <= p_extra + 1;
        end
    end
    always_comb begin
        p_rdata = 16'h0;
        if (p_rd && p_addr == 4'h4) p_rdata = {15'b0, pcnt == 0 && !p_never};
        if (p_rd && p_addr == 4'h6) p_rdata = {9'b0, pc_q};
    end

    // Reference: remainder of body*x^7 divided by x^7+x^3+1
    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [46:0] m;
        m = {2'b01, idx, arg, 7'b0};
        for (int i = 46; i >= 7; i--) if (m[i]) m[i-:8] = m[i-:8] ^ 8'h89;
        return {2'b01, idx, arg, m[6:0], 1'b1};
    endfunction

    logic [19:0] wlog[$];
    always @(negedge clk) begin
        if (p_wr) wlog.push_back({p_addr, p_wdata});
        chk("rd_wr_exclusive", {63'b0, p_rd & p_wr}, 64'd0);
        if (!busy) chk("idle_bus", {37'b0, p_cs, p_rd, p_wr, p_addr, p_wdata}, 64'd0);
    end

    task automatic chk_writes(input string name, input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b;
        logic [15:0] w[3];
        b = {2'b01, idx, arg};
        w[0] = b[39:24];
        w[1] = b[23:8];
        w[2] = {b[7:0], 8'h00};
        chk({name, "_wcount"}, wlog.size(), 9);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] ctl;
            ctl = {13'b0, k == 2, k == 0, 1'b0};
            chk({name, "_wdata"},  (wlog.size() > 3*k)   ? wlog[3*k]   : 20'hFFFFF, {4'h0, w[k]});
            chk({name, "_wsthi"},  (wlog.size() > 3*k+1) ? wlog[3*k+1] : 20'hFFFFF, {4'h2, ctl | 16'h1});
            chk({name, "_wstlo"},  (wlog.size() > 3*k+2) ? wlog[3*k+2] : 20'hFFFFF, {4'h2, ctl});
        end
    endtask

    // Launch one command; returns cycles to done/err (0 on timeout) and the outputs seen then
    task automatic run(input logic [5:0] idx, input logic [31:0] arg, input int extra, input bit never,
                       input bit start_at_end, output int lat, output logic dn, output logic er,
                       output logic [47:0] fr);
        p_extra = extra;
        p_never = never;
        lat = 0;
        @(negedge clk);
        wlog.delete();
        start = 1'b1;
        cmd_index = idx;
        cmd_arg = arg;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done || err) begin
                lat = k;
                break;
            end
            chk("busy_during_op", {63'b0, busy}, 64'd1);
            start = 1'($urandom_range(0, 1));
            cmd_index = 6'($urandom);
            cmd_arg = $urandom;
        end
        dn = done;
        er = err;
        fr = frame;
        if (lat == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_bound: no done/err within 400 cycles");
        end
        chk("busy_at_end", {63'b0, busy}, 64'd0);
        start = start_at_end;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        int          extra;
        logic [47:0] frame;
        int          lat;
    } vec_t;

    initial begin
        vec_t tv[4];
        int lat;
        logic dn, er;
        logic [47:0] fr, prev;
        tv[0] = '{6'd0, 32'h0,        0, 48'h400000000095, 15};
        tv[1] = '{6'd8, 32'h000001AA, 0, 48'h48000001AA87, 15};
        tv[2] = '{6'd0, 32'h0,        4, 48'h400000000095, 27};
        tv[3] = '{6'd8, 32'h000001AA, 1, 48'h48000001AA87, 18};
        repeat (3) @(negedge clk);
        chk("reset_ctl", {38'b0, busy, done, err, p_cs, p_rd, p_wr, p_addr, p_wdata}, 64'd0);
        chk("reset_frame", {16'b0, frame}, 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run(tv[i].idx, tv[i].arg, tv[i].extra, 0, 0, lat, dn, er, fr);
            chk("vec_latency", lat, tv[i].lat);
            chk("vec_done", {62'b0, dn, er}, 64'd2);
            chk("vec_frame", {16'b0, fr}, {16'b0, tv[i].frame});
            chk_writes("vec", tv[i].idx, tv[i].arg);
            @(negedge clk);
            chk("vec_done_pulse", {63'b0, done}, 64'd0);
            chk("vec_frame_hold", {16'b0, frame}, {16'b0, tv[i].frame});
        end
        for (int i = 0; i < 8; i++) begin
            logic [5:0]  ri;
            logic [31:0] ra;
            int          re;
            ri = 6'($urandom);
            ra = $urandom;
            re = $urandom_range(0, 3);
            run(ri, ra, re, 0, 0, lat, dn, er, fr);
            chk("rnd_latency", lat, 15 + 3 * re);
            chk("rnd_done", {63'b0, dn}, 64'd1);
            chk("rnd_frame", {16'b0, fr}, {16'b0, ref_frame(ri, ra)});
            chk_writes("rnd", ri, ra);
        end
        // Peripheral never finishes: timeout on W0, start during ERR ignored
        prev = frame;
        run(6'd5, 32'hDEADBEEF, 0, 1, 1, lat, dn, er, fr);
        chk("tmo_latency", lat, 4 + TMO);
        chk("tmo_flags", {62'b0, dn, er}, 64'd1);
        chk("tmo_frame", {16'b0, fr}, {16'b0, prev});
        chk("tmo_writes", wlog.size(), 3);
        repeat (5) begin
            @(negedge clk);
            chk("tmo_idle", {61'b0, busy, done, err}, 64'd1);
        end
        run(6'd17, 32'h0, 0, 0, 0, lat, dn, er, fr);
        chk("after_err", {62'b0, dn, er}, 64'd2);
        chk("after_err_frame", {16'b0, fr}, {16'b0, ref_frame(6'd17, 32'h0)});
        // Reset during POLL of W1
        p_extra = 4;
        p_never = 0;
        @(negedge clk);
        wlog.delete();
        start = 1'b1;
        cmd_index = 6'd3;
        cmd_arg = 32'h12345678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(negedge clk);
        chk("rst_in_poll", {59'b0, p_rd, p_addr}, 64'h14);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctl", {38'b0, busy, done, err, p_cs, p_rd, p_wr, p_addr, p_wdata}, 64'd0);
        chk("rst_mid_frame", {16'b0, frame}, 64'd0);
        rst = 1'b1;
        run(6'd9, 32'hCAFE0001, 2, 0, 1, lat, dn, er, fr);
        chk("post_rst_latency", lat, 21);
        chk("post_rst_frame", {16'b0, fr}, {16'b0, ref_frame(6'd9, 32'hCAFE0001)});
        chk_writes("post_rst", 6'd9, 32'hCAFE0001);
        // start was pulsed in the DONE cycle above: it must not launch a second frame
        repeat (6) begin
            @(negedge clk);
            chk("done_cycle_start", {62'b0, busy, done}, 64'd0);
        end
        chk("done_cycle_writes", wlog.size(), 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
